// File: rtl/axis_pkt_arbiter.sv
// axis_pkt_arbiter: two-input AXI-Stream packet arbiter in front of the AXIS FIFO.
// Whole packets are granted (locked until last) with round-robin tie breaking.
// Beats pass combinationally from the granted source to the FIFO write side.
// Optional feature macro: AXIS_ARB_MAXLEN_EN (packet truncation at MAX_LEN beats).
module axis_pkt_arbiter #(
  parameter int DW      = 8,
  parameter int MAX_LEN = 2048
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] s0_data,
  input  logic          s0_valid,
  input  logic          s0_last,
  output logic          s0_ready,
  input  logic [DW-1:0] s1_data,
  input  logic          s1_valid,
  input  logic          s1_last,
  output logic          s1_ready,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  output logic          m_last,
  output logic          m_wr_en,
  input  logic          m_ready,
  input  logic          fifo_full,
  output logic [1:0]    grant,
  output logic [15:0]   pkt_cnt0,
  output logic [15:0]   pkt_cnt1,
  output logic          trunc_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1
`ifdef AXIS_ARB_MAXLEN_EN
    , DROP = 2'd2
`endif
  } state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_grant_q, last_grant_d;
  logic          pkt_done;
  logic          xfer;
  logic          accept;
  logic          sel_valid;
  logic          sel_last;
  logic [DW-1:0] sel_data;

`ifdef AXIS_ARB_MAXLEN_EN
  localparam int BCW = $clog2(MAX_LEN) + 1;
  logic [BCW-1:0] beat_cnt_q;
  logic           at_max;
  assign at_max = (beat_cnt_q == BCW'(MAX_LEN - 1));
`else
  logic unused_max_len;
  assign unused_max_len = (MAX_LEN > 0) ? 1'b0 : 1'b1;
`endif

  assign sel_valid = owner_q ? s1_valid : s0_valid;
  assign sel_last  = owner_q ? s1_last  : s0_last;
  assign sel_data  = owner_q ? s1_data  : s0_data;
  assign accept    = m_ready & ~fifo_full;
  assign m_wr_en   = m_valid;

  // Next-state decision plus the combinational beat mux toward the FIFO
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    grant        = 2'b00;
    m_valid      = 1'b0;
    m_data       = '0;
    m_last       = 1'b0;
    s0_ready     = 1'b0;
    s1_ready     = 1'b0;
    pkt_done     = 1'b0;
    xfer         = 1'b0;
    trunc_err    = 1'b0;
    case (state_q)
      IDLE: begin
        if (s0_valid | s1_valid) begin
          state_d = XFER;
          if (s0_valid & s1_valid) owner_d = ~last_grant_q;
          else                     owner_d = s1_valid;
        end
      end
      XFER: begin
        grant    = owner_q ? 2'b10 : 2'b01;
        m_valid  = sel_valid;
        m_data   = sel_data;
        m_last   = sel_last;
        s0_ready = ~owner_q & accept;
        s1_ready = owner_q & accept;
        xfer     = sel_valid & accept;
`ifdef AXIS_ARB_MAXLEN_EN
        if (at_max) m_last = 1'b1;
`endif
        if (xfer) begin
          if (sel_last) begin
            pkt_done     = 1'b1;
            last_grant_d = owner_q;
            state_d      = IDLE;
          end
`ifdef AXIS_ARB_MAXLEN_EN
          else if (at_max) begin
            pkt_done  = 1'b1;
            trunc_err = 1'b1;
            state_d   = DROP;
          end
`endif
        end
      end
`ifdef AXIS_ARB_MAXLEN_EN
      DROP: begin
        grant    = owner_q ? 2'b10 : 2'b01;
        s0_ready = ~owner_q;
        s1_ready = owner_q;
        if (sel_valid & sel_last) begin
          last_grant_d = owner_q;
          state_d      = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State, owner, round-robin history and saturating packet counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      pkt_cnt0     <= '0;
      pkt_cnt1     <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      if (pkt_done && !owner_q && pkt_cnt0 != 16'hFFFF) pkt_cnt0 <= pkt_cnt0 + 16'd1;
      if (pkt_done && owner_q && pkt_cnt1 != 16'hFFFF)  pkt_cnt1 <= pkt_cnt1 + 16'd1;
    end
  end

`ifdef AXIS_ARB_MAXLEN_EN
  // Counts accepted beats of the current packet; cleared whenever XFER is left
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_cnt_q <= '0;
    end else if (state_q != XFER || state_d != XFER) begin
      beat_cnt_q <= '0;
    end else if (xfer) begin
      beat_cnt_q <= beat_cnt_q + BCW'(1);
    end
  end
`endif

endmodule
